// File: rtl/btn_pkg.sv
// Shared types for the push-button event detector: per-channel edge selection
// and the auto-repeat state machine encoding.
package btn_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        BOTH = 2'b11
    } edge_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        REPEAT = 2'b10
    } rep_state_t;

    // Auto-repeat only runs for modes that report presses.
    function automatic logic mode_repeats(input edge_mode_t mode);
        return (mode == RISE) || (mode == BOTH);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, consecutive-sample debounce, edge pulses,
// mode-selected event tick and optional auto-repeat while held.
module button_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_level,
    input  edge_mode_t i_mode,
    output logic       o_level,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_tick,
    output rep_state_t o_state
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_channel: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_channel: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 0) begin : g_bad_delay
        $error("button_channel: REPEAT_DELAY must be >= 0");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("button_channel: REPEAT_PERIOD must be >= 1");
    end

    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [HOLD_W-1:0] PER_LAST   = HOLD_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   tick_q, tick_d;
    rep_state_t             state_q, state_d;

    logic s;
    logic edge_tick;
    logic rep_tick;
    logic rep_ok;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_level};
        s       = sync_q[SYNC_STAGES-1];
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // A level change needs DEBOUNCE_CYCLES consecutive differing samples.
        if (s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        edge_tick = 1'b0;
        case (i_mode)
            RISE:    edge_tick = rise_d;
            FALL:    edge_tick = fall_d;
            BOTH:    edge_tick = rise_d | fall_d;
            default: edge_tick = 1'b0;
        endcase
    end

    always_comb begin
        rep_ok   = REPEAT_EN && mode_repeats(i_mode);
        state_d  = state_q;
        hold_d   = hold_q;
        rep_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_d && rep_ok) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (fall_d || !rep_ok) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == DELAY_LAST) begin
                    rep_tick = 1'b1;
                    state_d  = REPEAT;
                    hold_d   = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            REPEAT: begin
                if (fall_d || !rep_ok) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == PER_LAST) begin
                    rep_tick = 1'b1;
                    hold_d   = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
        tick_d = edge_tick | rep_tick;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            tick_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            tick_q  <= tick_d;
            state_q <= state_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_tick  = tick_q;
    assign o_state = state_q;

endmodule

// File: rtl/button_event_detector.sv
// Multi-channel push-button conditioner; each channel is an independent
// button_channel, and o_dbg_state exposes every repeat FSM state.
module button_event_detector
    import btn_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_CH-1:0]   i_level,
    input  logic [2*N_CH-1:0] i_mode,
    output logic [N_CH-1:0]   o_level,
    output logic [N_CH-1:0]   o_rise,
    output logic [N_CH-1:0]   o_fall,
    output logic [N_CH-1:0]   o_tick,
    output logic [2*N_CH-1:0] o_dbg_state
);

    if (N_CH < 1) begin : g_bad_nch
        $error("button_event_detector: N_CH must be >= 1");
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        rep_state_t ch_state;

        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_level(i_level[c]),
            .i_mode (edge_mode_t'(i_mode[2*c +: 2])),
            .o_level(o_level[c]),
            .o_rise (o_rise[c]),
            .o_fall (o_fall[c]),
            .o_tick (o_tick[c]),
            .o_state(ch_state)
        );

        assign o_dbg_state[2*c +: 2] = ch_state;
    end

endmodule

// File: tb/tb_button_event_detector.sv
// Bench for button_event_detector: directed scenarios plus random button
// activity, all compared against a sample-window / elapsed-time reference model.
module tb_button_event_detector;
    import btn_pkg::*;

    localparam int NC   = 2;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;
    localparam int HL   = SYNC + DEB;
    localparam int W    = 4 * NC;

    logic            i_clk;
    logic            i_rst_n;
    logic [NC-1:0]   i_level;
    logic [2*NC-1:0] i_mode;
    logic [NC-1:0]   o_level;
    logic [NC-1:0]   o_rise;
    logic [NC-1:0]   o_fall;
    logic [NC-1:0]   o_tick;
    logic [2*NC-1:0] o_dbg_state;

    button_event_detector #(
        .N_CH           (NC),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_level    (i_level),
        .i_mode     (i_mode),
        .o_level    (o_level),
        .o_rise     (o_rise),
        .o_fall     (o_fall),
        .o_tick     (o_tick),
        .o_dbg_state(o_dbg_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks;
    int errors;

    // Reference model: history of raw inputs per channel, debounced level,
    // and the edge number of the press that armed auto-repeat.
    bit            hist [NC][HL];
    logic [NC-1:0] m_lvl, m_rise, m_fall, m_tick;
    bit            armed [NC];
    int            rise_edge [NC];
    int            edge_no;

    logic [W-1:0] exp_q[$];

    int cnt_tick [NC];
    int cnt_rise [NC];
    int cnt_fall [NC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < HL; i++) hist[c][i] = 1'b0;
            armed[c]     = 1'b0;
            rise_edge[c] = 0;
        end
        m_lvl   = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_tick  = '0;
        edge_no = 0;
    endtask

    task automatic model_edge();
        bit         all_diff;
        bit         rep;
        bit         rep_ok;
        bit         edge_t;
        logic [1:0] md;
        int         el;
        edge_no++;
        for (int c = 0; c < NC; c++) begin
            for (int i = HL - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = i_level[c];
            // The synchronised sample seen i edges ago is the raw input SYNC+i edges ago.
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++)
                if (hist[c][SYNC+i] == m_lvl[c]) all_diff = 1'b0;
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (all_diff) begin
                m_lvl[c] = ~m_lvl[c];
                if (m_lvl[c]) m_rise[c] = 1'b1;
                else          m_fall[c] = 1'b1;
            end
            md     = i_mode[2*c +: 2];
            rep_ok = (md == RISE) || (md == BOTH);
            edge_t = ((md == RISE) && m_rise[c]) || ((md == FALL) && m_fall[c]) ||
                     ((md == BOTH) && (m_rise[c] || m_fall[c]));
            rep = 1'b0;
            if (m_rise[c] && rep_ok && (RD > 0)) begin
                armed[c]     = 1'b1;
                rise_edge[c] = edge_no;
            end else if (armed[c]) begin
                if (m_fall[c] || !rep_ok) begin
                    armed[c] = 1'b0;
                end else begin
                    el = edge_no - rise_edge[c];
                    if ((el >= RD) && (((el - RD) % RP) == 0)) rep = 1'b1;
                end
            end
            m_tick[c] = edge_t | rep;
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check(tag, 32'({o_tick, o_fall, o_rise, o_level}), 32'(e));
        for (int c = 0; c < NC; c++) begin
            cnt_tick[c] += int'(o_tick[c]);
            cnt_rise[c] += int'(o_rise[c]);
            cnt_fall[c] += int'(o_fall[c]);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        if (!i_rst_n) model_reset();
        else          model_edge();
        exp_q.push_back({m_tick, m_fall, m_rise, m_lvl});
        @(negedge i_clk);
        compare_outputs("cycle_outputs");
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NC; c++) begin
            cnt_tick[c] = 0;
            cnt_rise[c] = 0;
            cnt_fall[c] = 0;
        end
    endtask

    task automatic assert_reset();
        i_rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.push_back('0);
        compare_outputs("reset_async_outputs");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] sweep_mode [4];
        int         sweep_exp [4];
        bit         seen;
        int         hold_left [NC];

        sweep_mode = '{RISE, FALL, BOTH, OFF};
        sweep_exp  = '{1, 1, 2, 0};
        checks  = 0;
        errors  = 0;
        i_rst_n = 1'b0;
        i_level = '0;
        i_mode  = {RISE, RISE};
        clear_counts();
        model_reset();
        #1;
        exp_q.push_back('0);
        compare_outputs("reset_state");
        repeat (3) step();
        i_rst_n = 1'b1;
        repeat (3) step();

        // Single press on channel 0: level and rise exactly at edge 6.
        clear_counts();
        i_level[0] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            check("press_level_before_edge6", 32'(o_level[0]), 32'd0);
        end
        step();
        check("press_level_edge6", 32'(o_level[0]), 32'd1);
        check("press_rise_edge6", 32'(o_rise[0]), 32'd1);
        check("press_tick_edge6", 32'(o_tick[0]), 32'd1);
        step();
        check("press_rise_width", 32'(o_rise[0]), 32'd0);
        i_level[0] = 1'b0;
        repeat (12) step();
        check("press_fall_count", 32'(cnt_fall[0]), 32'd1);
        check("ch1_silent", 32'(cnt_rise[1] + cnt_fall[1] + cnt_tick[1]), 32'd0);

        // Glitch shorter than the debounce window, then one just long enough.
        clear_counts();
        i_level[0] = 1'b1;
        repeat (3) step();
        i_level[0] = 1'b0;
        repeat (10) step();
        check("glitch3_rise", 32'(cnt_rise[0]), 32'd0);
        check("glitch3_tick", 32'(cnt_tick[0]), 32'd0);
        clear_counts();
        i_level[0] = 1'b1;
        repeat (4) step();
        i_level[0] = 1'b0;
        repeat (12) step();
        check("pulse4_rise", 32'(cnt_rise[0]), 32'd1);
        check("pulse4_fall", 32'(cnt_fall[0]), 32'd1);

        // Mode sweep on a short press and release.
        for (int m = 0; m < 4; m++) begin
            i_mode[1:0] = sweep_mode[m];
            clear_counts();
            i_level[0] = 1'b1;
            repeat (8) step();
            i_level[0] = 1'b0;
            repeat (10) step();
            check("sweep_tick_count", 32'(cnt_tick[0]), 32'(sweep_exp[m]));
            check("sweep_rise_count", 32'(cnt_rise[0]), 32'd1);
            check("sweep_fall_count", 32'(cnt_fall[0]), 32'd1);
        end

        // Auto-repeat: ticks at +0, +10, +15, +20, +25, +30 after the rise.
        i_mode[1:0] = RISE;
        i_level[0]  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (o_rise[0]) seen = 1'b1;
        end
        check("rep_rise_seen", 32'(seen), 32'd1);
        check("rep_tick_at_0", 32'(o_tick[0]), 32'd1);
        for (int o = 1; o <= 30; o++) begin
            step();
            check("rep_tick_offset", 32'(o_tick[0]), 32'(o inside {10, 15, 20, 25, 30}));
            if (o == 25) i_level[0] = 1'b0;
        end
        clear_counts();
        repeat (15) step();
        check("rep_after_release_ticks", 32'(cnt_tick[0]), 32'd0);
        check("rep_after_release_fall", 32'(cnt_fall[0]), 32'd1);

        // Reset while channel 0 repeats and channel 1 is mid-debounce.
        i_mode     = {BOTH, RISE};
        i_level[0] = 1'b1;
        repeat (20) step();
        i_level[1] = 1'b1;
        repeat (3) step();
        assert_reset();
        repeat (2) step();
        i_rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            check("rst_level_before_edge6", 32'(o_level), 32'd0);
        end
        step();
        check("rst_rerise_edge6", 32'(o_rise), 32'b11);
        check("rst_retick_edge6", 32'(o_tick), 32'b11);
        i_level = '0;
        repeat (12) step();

        // Both channels pressed together with different modes.
        i_mode = {FALL, BOTH};
        clear_counts();
        i_level = 2'b11;
        repeat (8) step();
        i_level = 2'b00;
        repeat (10) step();
        check("dual_ch0_ticks", 32'(cnt_tick[0]), 32'd2);
        check("dual_ch1_ticks", 32'(cnt_tick[1]), 32'd1);
        check("dual_ch1_rise", 32'(cnt_rise[1]), 32'd1);

        // Random button activity, mode changes and occasional resets.
        for (int c = 0; c < NC; c++) hold_left[c] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                if (hold_left[c] == 0) begin
                    i_level[c] = ~i_level[c];
                    if ($urandom_range(0, 3) == 0) hold_left[c] = $urandom_range(18, 40);
                    else                           hold_left[c] = $urandom_range(1, 7);
                end else begin
                    hold_left[c]--;
                end
                if ($urandom_range(0, 39) == 0) i_mode[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 249) == 0) begin
                assert_reset();
                repeat ($urandom_range(1, 3)) step();
                i_rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
